// File: rtl/dlx_pkg.sv
// -----------------------------------------------------------------------------
// dlx_pkg
// Shared constants for the DLX write-back / register-file slice:
//   - default data and register-index widths
//   - bit positions inside the 2-bit WB control field
//   - encoding of the register-dump state machine
// -----------------------------------------------------------------------------
package dlx_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;

  // Bit indices inside WB_control_in
  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  // Dump FSM encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_SEND = SEND,
    S_DONE = DONE
  } dump_state_e;

endpackage

// File: rtl/wb_regfile_if.sv
// -----------------------------------------------------------------------------
// wb_regfile_if
// Groups the MEM/WB write-back inputs, the two ID-stage read ports and the
// register-dump valid/ready channel of wb_regfile.
//   master : pipeline / debug side (drives write-back, read addresses, dump
//            requests and dump_ready; receives read data and dump stream)
//   slave  : register file side
// -----------------------------------------------------------------------------
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  // Write-back path
  logic              enable;
  logic [1:0]        WB_control_in;
  logic [DATA_W-1:0] data_from_mem_in;
  logic [DATA_W-1:0] data_from_ALU_in;
  logic [ADDR_W-1:0] rw_in;

  // ID-stage read ports
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [DATA_W-1:0] bus_a;
  logic [DATA_W-1:0] bus_b;

  // Register dump channel
  logic              dump_start;
  logic              dump_ready;
  logic              dump_valid;
  logic [DATA_W-1:0] dump_data;
  logic [ADDR_W-1:0] dump_index;
  logic              dump_busy;
  logic              dump_done;

  modport master (
    output enable, WB_control_in, data_from_mem_in, data_from_ALU_in, rw_in,
    output ra, rb, dump_start, dump_ready,
    input  bus_a, bus_b, dump_valid, dump_data, dump_index, dump_busy, dump_done
  );

  modport slave (
    input  enable, WB_control_in, data_from_mem_in, data_from_ALU_in, rw_in,
    input  ra, rb, dump_start, dump_ready,
    output bus_a, bus_b, dump_valid, dump_data, dump_index, dump_busy, dump_done
  );

endinterface

// File: rtl/regfile_dump_fsm.sv
// -----------------------------------------------------------------------------
// regfile_dump_fsm
// Sequencer for streaming the register file over a valid/ready channel.
// Ports:
//   clock, reset    : system clock, synchronous active-high reset
//   dump_start_i    : 1-cycle request, honoured only in IDLE
//   dump_ready_i    : sink accepts the current word
//   dump_valid_o    : current index is being offered (SEND)
//   dump_busy_o     : SEND or DONE
//   dump_done_o     : 1-cycle pulse after the last register was accepted
//   dump_idx_o      : register number being offered; also the third read
//                     address into the register array
// -----------------------------------------------------------------------------
module regfile_dump_fsm #(
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dump_start_i,
  input  logic              dump_ready_i,
  output logic              dump_valid_o,
  output logic              dump_busy_o,
  output logic              dump_done_o,
  output logic [ADDR_W-1:0] dump_idx_o
);
  import dlx_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    dump_valid_o = 1'b0;
    dump_busy_o  = 1'b0;
    dump_done_o  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dump_start_i) begin
          state_d = S_SEND;
          idx_d   = '0;
        end
      end

      S_SEND: begin
        dump_valid_o = 1'b1;
        dump_busy_o  = 1'b1;
        // Without ready the index is held; the offered word keeps following
        // the live register contents through the read path.
        if (dump_ready_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        dump_busy_o = 1'b1;
        dump_done_o = 1'b1;
        state_d     = S_IDLE;
        idx_d       = '0;
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign dump_idx_o = idx_q;

endmodule

// File: rtl/wb_regfile.sv
// -----------------------------------------------------------------------------
// wb_regfile
// Write-back stage and 32x32 register file of the 5-stage DLX pipeline.
//   - selects load data or ALU result as the write-back datum
//   - writes it into the register file (R0 is hard-wired to zero)
//   - serves two combinational ID-stage read ports with same-cycle
//     write-to-read bypass
//   - streams all registers to the debug unit over a valid/ready channel
// Ports:
//   clock  : system clock, all state updates on posedge
//   reset  : synchronous active-high reset; clears every register and aborts
//            any dump in progress
//   wb     : wb_regfile_if slave (write-back inputs, read ports, dump channel)
// -----------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic       clock,
  input  logic       reset,
  wb_regfile_if.slave wb
);
  import dlx_pkg::*;

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int NUM_RD   = 3;  // ra, rb, dump index

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  logic [DATA_W-1:0] wb_data;
  logic              we;

  logic [ADDR_W-1:0] rd_addr [NUM_RD];
  logic [DATA_W-1:0] rd_data [NUM_RD];

  logic              dump_valid;
  logic [ADDR_W-1:0] dump_idx;

  // Write-back mux and write enable; a stall (enable=0) only blocks the write.
  assign wb_data = wb.WB_control_in[WB_MEMTOREG] ? wb.data_from_mem_in
                                                 : wb.data_from_ALU_in;
  assign we      = wb.enable & wb.WB_control_in[WB_REGWRITE] & (wb.rw_in != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we) begin
      regs_q[wb.rw_in] <= wb_data;
    end
  end

  // All three readers share one read function: R0 forced to zero, then the
  // in-flight write-back wins over the stored value.
  assign rd_addr[0] = wb.ra;
  assign rd_addr[1] = wb.rb;
  assign rd_addr[2] = dump_idx;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      assign rd_data[gi] = (rd_addr[gi] == '0)            ? '0      :
                           (we && (wb.rw_in == rd_addr[gi])) ? wb_data :
                           regs_q[rd_addr[gi]];
    end
  endgenerate

  assign wb.bus_a = rd_data[0];
  assign wb.bus_b = rd_data[1];

  regfile_dump_fsm #(
    .ADDR_W (ADDR_W)
  ) u_dump_fsm (
    .clock        (clock),
    .reset        (reset),
    .dump_start_i (wb.dump_start),
    .dump_ready_i (wb.dump_ready),
    .dump_valid_o (dump_valid),
    .dump_busy_o  (wb.dump_busy),
    .dump_done_o  (wb.dump_done),
    .dump_idx_o   (dump_idx)
  );

  assign wb.dump_valid = dump_valid;
  assign wb.dump_index = dump_idx;
  // Outside SEND the data lane is parked at zero.
  assign wb.dump_data  = dump_valid ? rd_data[2] : '0;

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboarded bench for wb_regfile: stimulus pushes expectations into queues,
// a negedge monitor pops and compares when a probe is raised or a dump word is
// handshaked.
module tb_wb_regfile;
  import dlx_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;

  wb_regfile_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus)
  );

  always #5 clock = ~clock;

  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int got_done = 0;
  int exp_done = 0;
  int last_acc = -10;

  bit probe_a = 0;
  bit probe_b = 0;
  bit probe_s = 0;

  logic [31:0] exp_a [$];
  logic [31:0] exp_b [$];
  logic [39:0] exp_s [$];  // {valid, busy, done, index[4:0], data[31:0]}
  logic [36:0] exp_d [$];  // {index[4:0], data[31:0]}

  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
  end

  // Monitor / scoreboard
  initial forever begin
    logic [31:0] e32;
    logic [39:0] e40;
    logic [39:0] g40;
    logic [36:0] e37;
    logic [36:0] g37;
    @(negedge clock);
    if (probe_a) begin
      n_cmp++;
      if (exp_a.size() == 0) begin
        n_err++;
        $display("FAIL bus_a: got %h, nothing expected", bus.bus_a);
      end else begin
        e32 = exp_a.pop_front();
        if (bus.bus_a !== e32) begin
          n_err++;
          $display("FAIL bus_a ra=%0d: got %h expected %h", bus.ra, bus.bus_a, e32);
        end else $display("bus_a ra=%0d = %h ok", bus.ra, bus.bus_a);
      end
    end
    if (probe_b) begin
      n_cmp++;
      if (exp_b.size() == 0) begin
        n_err++;
        $display("FAIL bus_b: got %h, nothing expected", bus.bus_b);
      end else begin
        e32 = exp_b.pop_front();
        if (bus.bus_b !== e32) begin
          n_err++;
          $display("FAIL bus_b rb=%0d: got %h expected %h", bus.rb, bus.bus_b, e32);
        end else $display("bus_b rb=%0d = %h ok", bus.rb, bus.bus_b);
      end
    end
    if (probe_s) begin
      n_cmp++;
      g40 = {bus.dump_valid, bus.dump_busy, bus.dump_done, bus.dump_index, bus.dump_data};
      if (exp_s.size() == 0) begin
        n_err++;
        $display("FAIL status: got %h, nothing expected", g40);
      end else begin
        e40 = exp_s.pop_front();
        if (g40 !== e40) begin
          n_err++;
          $display("FAIL status {v,b,d,idx,data}: got %h expected %h", g40, e40);
        end else $display("status %h ok", g40);
      end
    end
    if (bus.dump_valid === 1'b1 && bus.dump_ready === 1'b1) begin
      n_cmp++;
      g37 = {bus.dump_index, bus.dump_data};
      if (exp_d.size() == 0) begin
        n_err++;
        $display("FAIL dump_word: unexpected idx=%0d data=%h", bus.dump_index, bus.dump_data);
      end else begin
        e37 = exp_d.pop_front();
        if (g37 !== e37) begin
          n_err++;
          $display("FAIL dump_word: got idx=%0d data=%h expected idx=%0d data=%h",
                   g37[36:32], g37[31:0], e37[36:32], e37[31:0]);
        end else $display("dump word idx=%0d data=%h ok", g37[36:32], g37[31:0]);
      end
      if (bus.dump_index == 5'd31) last_acc = cyc;
    end
    if (bus.dump_done === 1'b1) begin
      got_done++;
      n_cmp++;
      if (cyc != last_acc + 1) begin
        n_err++;
        $display("FAIL dump_done_latency: got %0d cycles after last word, expected 1",
                 cyc - last_acc);
      end else $display("dump_done pulse ok");
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    probe_a = 0;
    probe_b = 0;
    probe_s = 0;
  endtask

  task automatic wb(input logic [1:0] c, input logic [4:0] rw,
                    input logic [31:0] alu, input logic [31:0] mem, input logic en);
    bus.WB_control_in    = c;
    bus.rw_in            = rw;
    bus.data_from_ALU_in = alu;
    bus.data_from_mem_in = mem;
    bus.enable           = en;
  endtask

  task automatic wb_idle();
    wb(2'b00, 5'd0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic expect_a(input logic [4:0] a, input logic [31:0] v);
    bus.ra = a; probe_a = 1; exp_a.push_back(v);
  endtask

  task automatic expect_b(input logic [4:0] a, input logic [31:0] v);
    bus.rb = a; probe_b = 1; exp_b.push_back(v);
  endtask

  task automatic expect_s(input logic v, input logic b, input logic d,
                          input logic [4:0] i, input logic [31:0] dt);
    probe_s = 1; exp_s.push_back({v, b, d, i, dt});
  endtask

  task automatic wait_done(input int start_at);
    int k = 0;
    while (got_done < exp_done && k < 100) begin
      bus.dump_start = (k == start_at);
      tick();
      k++;
    end
    bus.dump_start = 0;
    if (got_done < exp_done) begin
      n_cmp++; n_err++;
      $display("FAIL dump_done_timeout: got %0d pulses expected %0d", got_done, exp_done);
    end
  endtask

  task automatic wait_index(input logic [4:0] target);
    int k = 0;
    while (!(bus.dump_valid === 1'b1 && bus.dump_index == target) && k < 60) begin
      tick();
      k++;
    end
    if (k >= 60) begin
      n_cmp++; n_err++;
      $display("FAIL dump_index_timeout: got idx=%0d expected %0d", bus.dump_index, target);
    end
  endtask

  initial begin
    wb_idle();
    bus.ra = 0; bus.rb = 0;
    bus.dump_start = 0; bus.dump_ready = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    // Reset state
    expect_s(0, 0, 0, 5'd0, 32'h0);
    expect_a(5'd3, 32'h0);
    tick();

    // 1: ALU write, read next cycle
    wb(2'b01, 5'd5, 32'h1234, 32'hFFFF_0000, 1);
    tick(); wb_idle(); expect_a(5'd5, 32'h1234);

    // 2: load write with same-cycle bypass, then stored value
    tick(); wb(2'b11, 5'd7, 32'h5555_5555, 32'hCAFE_BABE, 1); expect_b(5'd7, 32'hCAFE_BABE);
    tick(); wb_idle(); expect_b(5'd7, 32'hCAFE_BABE);

    // 3: R0 stays zero; stalled write and MemtoReg-only write are dropped
    tick(); wb(2'b01, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1); expect_a(5'd0, 32'h0);
    tick(); wb_idle(); expect_a(5'd0, 32'h0);
    tick(); wb(2'b01, 5'd5, 32'hDEAD, 32'h0, 0); expect_a(5'd5, 32'h1234);
    tick(); wb(2'b10, 5'd5, 32'hBEEF, 32'hBEEF, 1); expect_a(5'd5, 32'h1234);
    tick(); wb_idle(); expect_a(5'd5, 32'h1234);

    // 4: preload r_i = i*0x11 (odd via memory path), full dump
    for (int i = 1; i < 32; i++) begin
      tick();
      if (i % 2 == 1) wb(2'b11, 5'(i), 32'hBAD0_0000, 32'(i * 32'h11), 1);
      else            wb(2'b01, 5'(i), 32'(i * 32'h11), 32'hBAD0_0000, 1);
    end
    tick(); wb_idle(); expect_a(5'd31, 32'h20F); expect_b(5'd1, 32'h11);
    for (int i = 0; i < 32; i++) exp_d.push_back({5'(i), 32'(i * 32'h11)});
    exp_done++;
    bus.dump_ready = 1; bus.dump_start = 1;
    tick();
    bus.dump_start = 0;
    wait_done(5);  // a start pulse mid-dump must be ignored
    tick(); expect_s(0, 0, 0, 5'd0, 32'h0);

    // 5: stall at idx 10 while r10 is rewritten
    tick();
    for (int i = 0; i < 32; i++)
      exp_d.push_back({5'(i), (i == 10) ? 32'hAA : 32'(i * 32'h11)});
    exp_done++;
    bus.dump_ready = 1; bus.dump_start = 1;
    tick();
    bus.dump_start = 0;
    wait_index(5'd10);
    bus.dump_ready = 0; expect_s(1, 1, 0, 5'd10, 32'hAA);
    tick(); wb(2'b01, 5'd10, 32'hDEAD_0010, 32'h0, 1); expect_s(1, 1, 0, 5'd10, 32'hDEAD_0010);
    tick(); wb(2'b11, 5'd10, 32'h7777_7777, 32'hAA, 1); expect_s(1, 1, 0, 5'd10, 32'hAA);
    tick(); wb_idle(); bus.dump_ready = 1;
    wait_done(-1);
    tick();

    // 6: reset at idx 20 aborts the dump and clears registers
    for (int i = 0; i < 20; i++) exp_d.push_back({5'(i), 32'(i * 32'h11)});
    bus.dump_ready = 1; bus.dump_start = 1;
    tick();
    bus.dump_start = 0;
    wait_index(5'd20);
    bus.dump_ready = 0; reset = 1;
    tick();
    reset = 0;
    expect_s(0, 0, 0, 5'd0, 32'h0); expect_a(5'd10, 32'h0); expect_b(5'd31, 32'h0);
    tick(); expect_s(0, 0, 0, 5'd0, 32'h0); expect_a(5'd20, 32'h0); expect_b(5'd1, 32'h0);
    repeat (3) tick();

    // End-of-run bookkeeping
    n_cmp++;
    if (got_done != exp_done) begin
      n_err++;
      $display("FAIL dump_done_count: got %0d expected %0d", got_done, exp_done);
    end else $display("dump_done count %0d ok", got_done);
    n_cmp++;
    if (exp_d.size() != 0 || exp_a.size() != 0 || exp_b.size() != 0 || exp_s.size() != 0) begin
      n_err++;
      $display("FAIL leftover_expectations: got %0d dump words unconsumed, expected 0",
               exp_d.size());
    end else $display("all expectations consumed");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
